// File: rtl/memory_access_stage.sv
// MIPS memory stage: data access over an Avalon-style bus with waitrequest, pipeline stall and load
// formatting. Optional misaligned-access trapping is enabled with ALIGNMENT_CHECK_EN.
module memory_access_stage #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     memory_to_register_memory,
  input  logic                     memory_to_write_memory,
  input  logic [1:0]               access_size_memory,
  input  logic                     load_unsigned_memory,
  input  logic [ADDRESS_WIDTH-1:0] ALU_output_memory,
  input  logic [DATA_WIDTH-1:0]    write_data_memory,
  output logic [DATA_WIDTH-1:0]    read_data_memory,
  output logic                     stall_memory,
  output logic                     address_error_memory,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [3:0]               mem_byteenable,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  input  logic [DATA_WIDTH-1:0]    mem_readdata,
  input  logic                     mem_waitrequest
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e                   state_q, state_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_write_q, mem_write_d;
  logic [3:0]               byteenable_q, byteenable_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    writedata_q, writedata_d;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic                     addr_err_q, addr_err_d;
  logic [1:0]               lane_q, lane_d;
  logic [1:0]               size_q, size_d;
  logic                     unsigned_q, unsigned_d;

  logic                  request;
  logic [1:0]            lane;
  logic                  misaligned;
  logic [3:0]            be_new;
  logic [DATA_WIDTH-1:0] wd_new;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_fmt;

  assign request      = memory_to_register_memory | memory_to_write_memory;
  assign lane         = ALU_output_memory[1:0];
  assign stall_memory = request & (state_q != StDone);

`ifdef ALIGNMENT_CHECK_EN
  // Reserved size 2'b10 is treated as a word, hence the test on size[1] alone.
  assign misaligned = ((access_size_memory == 2'b01) & lane[0]) |
                      (access_size_memory[1] & (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_new = 4'b1111;
    wd_new = write_data_memory;
    unique case (access_size_memory)
      2'b00: begin
        be_new = 4'b0001 << lane;
        wd_new = {4{write_data_memory[7:0]}};
      end
      2'b01: begin
        be_new = lane[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{write_data_memory[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting uses the lane/size captured at request time.
  always_comb begin
    byte_sel = mem_readdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    unique case (size_q)
      2'b00:   load_fmt = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{~unsigned_q & half_sel[15]}}, half_sel};
      default: load_fmt = mem_readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    byteenable_d = byteenable_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    read_data_d  = read_data_q;
    addr_err_d   = 1'b0;
    lane_d       = lane_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    unique case (state_q)
      StIdle: begin
        if (request) begin
          if (misaligned) begin
            addr_err_d = 1'b1;
            state_d    = StDone;
          end else begin
            // A store wins over a simultaneous load.
            mem_write_d  = memory_to_write_memory;
            mem_read_d   = ~memory_to_write_memory;
            byteenable_d = be_new;
            address_d    = {ALU_output_memory[ADDRESS_WIDTH-1:2], 2'b00};
            writedata_d  = wd_new;
            lane_d       = lane;
            size_d       = access_size_memory;
            unsigned_d   = load_unsigned_memory;
            state_d      = StBus;
          end
        end
      end
      StBus: begin
        if (!mem_waitrequest) begin
          if (mem_read_q) read_data_d = load_fmt;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      byteenable_q <= '0;
      address_q    <= '0;
      writedata_q  <= '0;
      read_data_q  <= '0;
      addr_err_q   <= 1'b0;
      lane_q       <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      byteenable_q <= byteenable_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      read_data_q  <= read_data_d;
      addr_err_q   <= addr_err_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
    end
  end

  assign read_data_memory     = read_data_q;
  assign address_error_memory = addr_err_q;
  assign mem_address          = address_q;
  assign mem_read             = mem_read_q;
  assign mem_write            = mem_write_q;
  assign mem_byteenable       = byteenable_q;
  assign mem_writedata        = writedata_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: vector table run through a scoreboard queue,
// plus reset, idle and mid-transaction reset sequences.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld, st, uns;
  logic [1:0]  sz;
  logic [31:0] alu, wd;
  logic [31:0] read_data;
  logic        stall, addr_err;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_wait;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .memory_to_register_memory (ld),
    .memory_to_write_memory    (st),
    .access_size_memory        (sz),
    .load_unsigned_memory      (uns),
    .ALU_output_memory         (alu),
    .write_data_memory         (wd),
    .read_data_memory          (read_data),
    .stall_memory              (stall),
    .address_error_memory      (addr_err),
    .mem_address               (mem_address),
    .mem_read                  (mem_read),
    .mem_write                 (mem_write),
    .mem_byteenable            (mem_be),
    .mem_writedata             (mem_wdata),
    .mem_readdata              (mem_rdata),
    .mem_waitrequest           (mem_wait)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    int          exp_stall;
    int          exp_strobes;
    logic        exp_rds;
    logic        exp_wrs;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one access on the posedge after the previous DONE, acts as the slave, checks at DONE.
  task automatic run_access(input vec_t v, input int idx);
    vec_t        e;
    int          stall_cnt, strobe_cnt;
    logic        rd_seen, wr_seen, unstable, done;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    string       t;
    stall_cnt = 0; strobe_cnt = 0; rd_seen = 0; wr_seen = 0; unstable = 0; done = 0;
    cap_addr = '0; cap_wd = '0; cap_be = '0;
    t = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    ld = v.ld; st = v.st; sz = v.sz; uns = v.uns; alu = v.addr; wd = v.wd;
    mem_rdata = v.rdata; mem_wait = 1'b0;
    sb.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (strobe_cnt == 0) begin
          cap_addr = mem_address; cap_be = mem_be; cap_wd = mem_wdata;
        end else if (cap_addr !== mem_address || cap_be !== mem_be || cap_wd !== mem_wdata) begin
          unstable = 1'b1;
        end
        strobe_cnt++;
        rd_seen = rd_seen | mem_read;
        wr_seen = wr_seen | mem_write;
        mem_wait = (strobe_cnt <= v.waits);
      end
      if (stall) stall_cnt++;
      else done = 1'b1;
    end
    e = sb.pop_front();
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: stall never released after %0d cycles", t, stall_cnt);
    end
    check({t, "_rdata"}, read_data, e.exp_rd);
    check({t, "_stall_cycles"}, stall_cnt, e.exp_stall);
    check({t, "_strobe_cycles"}, strobe_cnt, e.exp_strobes);
    check({t, "_read_strobe"}, {31'd0, rd_seen}, {31'd0, e.exp_rds});
    check({t, "_write_strobe"}, {31'd0, wr_seen}, {31'd0, e.exp_wrs});
    check({t, "_addr_err"}, {31'd0, addr_err}, {31'd0, e.exp_err});
    if (e.exp_strobes > 0) begin
      check({t, "_address"}, cap_addr, e.exp_addr);
      check({t, "_byteenable"}, {28'd0, cap_be}, {28'd0, e.exp_be});
      check({t, "_stable"}, {31'd0, unstable}, 32'd0);
    end
    if (e.exp_wrs) check({t, "_writedata"}, cap_wd, e.exp_wd);
  endtask

  task automatic idle_check(input int n);
    @(posedge clk); #1;
    ld = 1'b0; st = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_stall", i), {31'd0, stall}, 32'd0);
      check($sformatf("idle%0d_strobes", i), {30'd0, mem_read, mem_write}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string t);
    check({t, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    check({t, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check({t, "_byteenable"}, {28'd0, mem_be}, 32'd0);
    check({t, "_address"}, mem_address, 32'd0);
    check({t, "_writedata"}, mem_wdata, 32'd0);
    check({t, "_rdata"}, read_data, 32'd0);
    check({t, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    check({t, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    //          ld st sz     uns addr   wd            rdata         w  exp_rd        exp_wd        be       exp_addr   stl stb rds wrs err
    vecs[0]  = '{1, 0, 2'b11, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0,        4'b1111, 32'h10, 2, 1, 1, 0, 0};
    vecs[1]  = '{1, 0, 2'b00, 0, 32'h13, 32'h0,        32'h80ABCDEF, 0, 32'hFFFFFF80, 32'h0,        4'b1000, 32'h10, 2, 1, 1, 0, 0};
    vecs[2]  = '{1, 0, 2'b00, 1, 32'h13, 32'h0,        32'h80ABCDEF, 0, 32'h00000080, 32'h0,        4'b1000, 32'h10, 2, 1, 1, 0, 0};
    vecs[3]  = '{0, 1, 2'b01, 0, 32'h22, 32'h00001234, 32'h0,        3, 32'h00000080, 32'h12341234, 4'b1100, 32'h20, 5, 4, 0, 1, 0};
    vecs[4]  = '{1, 1, 2'b11, 0, 32'h40, 32'hCAFEF00D, 32'h55555555, 0, 32'h00000080, 32'hCAFEF00D, 4'b1111, 32'h40, 2, 1, 0, 1, 0};
    vecs[5]  = '{1, 0, 2'b01, 0, 32'h02, 32'h0,        32'h80017FFF, 1, 32'hFFFF8001, 32'h0,        4'b1100, 32'h00, 3, 2, 1, 0, 0};
    vecs[6]  = '{1, 0, 2'b01, 1, 32'h04, 32'h0,        32'h1234F00F, 0, 32'h0000F00F, 32'h0,        4'b0011, 32'h04, 2, 1, 1, 0, 0};
    vecs[7]  = '{0, 1, 2'b00, 0, 32'h31, 32'h000000A5, 32'h0,        1, 32'h0000F00F, 32'hA5A5A5A5, 4'b0010, 32'h30, 3, 2, 0, 1, 0};
    vecs[8]  = '{1, 0, 2'b00, 0, 32'h01, 32'h0,        32'h00007F00, 2, 32'h0000007F, 32'h0,        4'b0010, 32'h00, 4, 3, 1, 0, 0};
    vecs[9]  = '{1, 0, 2'b10, 0, 32'h08, 32'h0,        32'h11223344, 0, 32'h11223344, 32'h0,        4'b1111, 32'h08, 2, 1, 1, 0, 0};
`ifdef ALIGNMENT_CHECK_EN
    vecs[10] = '{1, 0, 2'b11, 0, 32'h42, 32'h0,        32'h13579BDF, 0, 32'h11223344, 32'h0,        4'b0000, 32'h00, 1, 0, 0, 0, 1};
`else
    vecs[10] = '{1, 0, 2'b11, 0, 32'h42, 32'h0,        32'h13579BDF, 0, 32'h13579BDF, 32'h0,        4'b1111, 32'h40, 2, 1, 1, 0, 0};
`endif
    vecs[11] = '{1, 0, 2'b00, 0, 32'h02, 32'h0,        32'h00FE0000, 0, 32'hFFFFFFFE, 32'h0,        4'b0100, 32'h00, 2, 1, 1, 0, 0};
    vecs[12] = '{0, 1, 2'b11, 0, 32'h4C, 32'h89ABCDEF, 32'h0,        0, 32'hFFFFFFFE, 32'h89ABCDEF, 4'b1111, 32'h4C, 2, 1, 0, 1, 0};

    reset_n = 1'b0; ld = 0; st = 0; sz = 2'b11; uns = 0; alu = '0; wd = '0;
    mem_rdata = '0; mem_wait = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    idle_check(3);

    // Back-to-back accesses through the scoreboard.
    for (int i = 0; i < 13; i++) run_access(vecs[i], i);
    check("scoreboard_empty", sb.size(), 32'd0);

    idle_check(2);

    // Reset while the bus is held off by waitrequest.
    @(posedge clk); #1;
    st = 1'b1; ld = 1'b0; sz = 2'b11; alu = 32'h50; wd = 32'h55AA55AA; mem_wait = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_write_held", {31'd0, mem_write}, 32'd1);
    check("midrst_stall_held", {31'd0, stall}, 32'd1);
    reset_n = 1'b0; st = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    reset_n = 1'b1; mem_wait = 1'b0;
    idle_check(1);

    run_access('{1, 0, 2'b11, 0, 32'h60, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 32'h0, 4'b1111,
                 32'h60, 3, 2, 1, 0, 0}, 99);
    idle_check(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
